// File: rtl/coord_sub_arbiter.sv
// Round-robin arbiter sharing one signed coordinate subtractor among N_REQ requesters.
// Optional build macro COORD_SUB_SAT_EN: saturate instead of wrap when CCX < WCX+1.
module coord_sub_arbiter #(
  parameter int N_REQ = 4,
  parameter int WCX   = 8,
  parameter int CCX   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][WCX-1:0]     req_a,
  input  logic [N_REQ-1:0][WCX-1:0]     req_b,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic [CCX-1:0]                rsp_diff
);
  localparam int IDW = $clog2(N_REQ);

  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [CCX-1:0] rsp_diff_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] rr_ptr_next;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic           accept;
  logic           xfer;
  logic [WCX-1:0] a_sel;
  logic [WCX-1:0] b_sel;
  logic [CCX-1:0] diff_f;

  // Rotating priority search starting at rr_ptr; depends only on requests, never on rsp_ready.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign accept      = !rsp_valid_reg || rsp_ready;
  assign xfer        = rst_n && grant_any && accept;
  assign rr_ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign a_sel       = req_a[grant_id];
  assign b_sel       = req_b[grant_id];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer && (grant_id == IDW'(gi));
    end

    if (CCX >= WCX + 1) begin : g_ext
      logic signed [WCX:0] d;
      assign d = $signed({a_sel[WCX-1], a_sel}) - $signed({b_sel[WCX-1], b_sel});
      if (CCX == WCX + 1) begin : g_exact
        assign diff_f = d;
      end else begin : g_sext
        assign diff_f = {{(CCX-WCX-1){d[WCX]}}, d};
      end
    end else begin : g_narrow
`ifdef COORD_SUB_SAT_EN
      logic signed [WCX:0]     d;
      logic [WCX-CCX+1:0]      upper;
      logic                    in_range;
      assign d        = $signed({a_sel[WCX-1], a_sel}) - $signed({b_sel[WCX-1], b_sel});
      // Representable exactly when every bit above the result sign bit matches it.
      assign upper    = d[WCX:CCX-1];
      assign in_range = (&upper) || !(|upper);
      assign diff_f   = in_range ? d[CCX-1:0]
                      : d[WCX]   ? {1'b1, {(CCX-1){1'b0}}}
                                 : {1'b0, {(CCX-1){1'b1}}};
`else
      // Low CCX bits of the exact difference equal the low bits of a modular subtract.
      assign diff_f = CCX'(a_sel - b_sel);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_diff_reg  <= '0;
      rr_ptr_reg    <= '0;
    end else if (xfer) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= grant_id;
      rsp_diff_reg  <= diff_f;
      rr_ptr_reg    <= rr_ptr_next;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_diff  = rsp_diff_reg;

endmodule

// File: tb/tb_coord_sub_arbiter.sv
// Randomized + directed scoreboard bench for coord_sub_arbiter (N_REQ=4, WCX=8, CCX=8).
// Honours COORD_SUB_SAT_EN in the reference arithmetic.
module tb_coord_sub_arbiter;
  localparam int N   = 4;
  localparam int WCX = 8;
  localparam int CCX = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N-1:0]            req_valid;
  logic [N-1:0][WCX-1:0]   req_a;
  logic [N-1:0][WCX-1:0]   req_b;
  logic [N-1:0]            req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [CCX-1:0]          rsp_diff;

  coord_sub_arbiter #(.N_REQ(N), .WCX(WCX), .CCX(CCX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_diff(rsp_diff)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Requester-side pending operations and reference-model state.
  bit                     pend [N];
  logic signed [WCX-1:0]  pa [N];
  logic signed [WCX-1:0]  pb [N];
  bit                     m_full;
  int                     m_rr;
  int                     exp_id [$];
  int                     exp_diff [$];

  function automatic int fref(input int a, input int b);
    int d, lo, hi, m;
    d  = a - b;
    lo = -(1 << (CCX - 1));
    hi = (1 << (CCX - 1)) - 1;
    m  = 1 << CCX;
    if (CCX >= WCX + 1) return d;
`ifdef COORD_SUB_SAT_EN
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
`else
    d = ((d % m) + m) % m;
    if (d > hi) d = d - m;
    return d;
`endif
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[i]     = pa[i];
      req_b[i]     = pb[i];
    end
  endtask

  task automatic load(input int i, input int a, input int b);
    pend[i] = 1'b1;
    pa[i]   = WCX'(a);
    pb[i]   = WCX'(b);
  endtask

  // Reference arbitration for the current cycle: oldest-pointer-first search over pending ops.
  task automatic model_check();
    logic [N-1:0] exp_ready;
    int g;
    bit acc;
    exp_ready = '0;
    g   = -1;
    acc = !m_full || rsp_ready;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    if (g >= 0 && acc) exp_ready[g] = 1'b1;
    if (req_ready !== exp_ready) check("req_ready", int'(req_ready), int'(exp_ready));
    else check("req_ready", int'(req_ready), int'(exp_ready));
    check("rsp_valid", (rsp_valid === 1'b1) ? 1 : 0, m_full ? 1 : 0);
    if (exp_ready != '0) begin
      exp_id.push_back(g);
      exp_diff.push_back(fref(int'(pa[g]), int'(pb[g])));
      $display("grant req %0d a=%0d b=%0d", g, pa[g], pb[g]);
      pend[g] = 1'b0;
      m_rr    = (g + 1) % N;
      m_full  = 1'b1;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic step(input int prob, input bit rdy);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < prob) begin
        pend[i] = 1'b1;
        pa[i]   = WCX'($urandom);
        pb[i]   = WCX'($urandom);
      end
    end
    drive_inputs();
    rsp_ready = rdy;
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset(input logic [N-1:0] vmask);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = vmask[i];
      pa[i]   = WCX'($urandom);
      pb[i]   = WCX'($urandom);
    end
    drive_inputs();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset req_ready", int'(req_ready), 0);
      @(posedge clk); #1;
      check("reset rsp_valid", (rsp_valid === 1'b0) ? 0 : 1, 0);
    end
    rst_n  = 1'b1;
    m_full = 1'b0;
    m_rr   = 0;
    exp_id.delete();
    exp_diff.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    model_check();
  endtask

  // Monitor: compares the presented result with the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_id.size() == 0) begin
        check("unexpected rsp", 1, 0);
      end else begin
        check("rsp_id", int'(rsp_id), exp_id[0]);
        check("rsp_diff", int'($signed(rsp_diff)), exp_diff[0]);
        $display("rsp id=%0d diff=%0d ready=%0b", rsp_id, $signed(rsp_diff), rsp_ready);
        if (rsp_ready) begin
          void'(exp_id.pop_front());
          void'(exp_diff.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    m_full = 1'b0;
    m_rr   = 0;

    // Reset with all requesting: first post-release grant goes to requester 0.
    do_reset(4'b1111);
    repeat (6) step(0, 1'b1);

    // Single op on requester 2.
    load(2, 100, 30);
    step(0, 1'b1);
    repeat (2) step(0, 1'b1);

    // Continuous round-robin, no bubbles.
    repeat (8) step(100, 1'b1);
    repeat (6) step(0, 1'b1);

    // Backpressure: hold a result for 5 cycles, then drain with a same-cycle grant.
    for (int i = 0; i < N; i++) load(i, i * 10, -i);
    step(0, 1'b1);
    repeat (5) step(0, 1'b0);
    repeat (6) step(0, 1'b1);

    // Overflow corners.
    load(0, 100, -100);
    load(1, -128, 127);
    load(2, 127, -128);
    load(3, -128, -128);
    repeat (7) step(0, 1'b1);

    // Reset while a result is held under backpressure.
    load(1, 5, 9);
    step(0, 1'b0);
    step(0, 1'b0);
    do_reset(4'b0000);
    load(3, -7, 20);
    step(0, 1'b1);
    repeat (3) step(0, 1'b1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) step(40, ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
    repeat (12) step(0, 1'b1);

    check("scoreboard drained", exp_id.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
